// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its pending scoreboard.
package regfile_mp_pkg;

  localparam int DW_DEF     = 32;
  localparam int AW_DEF     = 5;
  localparam int NR_DEF     = 2;
  localparam int NW_DEF     = 2;
  localparam int BYPASS_DEF = 1;

  // Scoreboard bit values: a busy register has an outstanding producer.
  localparam logic SB_BUSY = 1'b1;
  localparam logic SB_FREE = 1'b0;

  // Active levels of the per-port read and write enables.
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between ID/WB stages and the register file: write ports, read ports, issue marking.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF,
  parameter int NW = NW_DEF
) ();

  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             set_en;
  logic [AW-1:0]    set_addr;

  modport master (
    output we, waddr, wdata, re, raddr, set_en, set_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, set_en, set_addr,
    output rdata, rbusy
  );

endinterface

// File: rtl/regfile_mp_sb.sv
// Pending scoreboard: one bit per register, set at issue, cleared at writeback.
// Busy lookups here are raw; the top masks them with the write-bypass condition.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF,
  parameter int NW = NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR-1:0]    busy
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Next pending state: writebacks clear first, then issue sets so the younger producer wins.
  always_comb begin
    pend_nxt = pend;
    for (int k = 0; k < NW; k++) begin
      if ((we[k] == WRITE_ENABLE) && (waddr[k*AW +: AW] != {AW{1'b0}})) begin
        pend_nxt[waddr[k*AW +: AW]] = SB_FREE;
      end else begin
        pend_nxt = pend_nxt;
      end
    end
    if (set_en && (set_addr != {AW{1'b0}})) begin
      pend_nxt[set_addr] = SB_BUSY;
    end else begin
      pend_nxt = pend_nxt;
    end
    pend_nxt[0] = SB_FREE;
  end

  // Pending bit storage, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= {NREG{SB_FREE}};
    end else begin
      pend <= pend_nxt;
    end
  end

  // Raw busy lookup per read port; R0 is never busy.
  always_comb begin
    busy = {NR{SB_FREE}};
    for (int j = 0; j < NR; j++) begin
      if (raddr[j*AW +: AW] != {AW{1'b0}}) begin
        busy[j] = pend[raddr[j*AW +: AW]];
      end else begin
        busy[j] = SB_FREE;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NW prioritised write ports, NR combinational read ports with
// optional same-cycle bypass, R0 hardwired to zero, per-register pending scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NR     = NR_DEF,
  parameter int NW     = NW_DEF,
  parameter int BYPASS = BYPASS_DEF
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0]    regs [NREG];
  logic [NW-1:0]    wr_ok;
  logic [NR-1:0]    sb_busy;
  logic [NR-1:0]    whit;
  logic [DW-1:0]    wbyp [NR];
  logic [NR*DW-1:0] rdata_c;
  logic [NR-1:0]    rbusy_c;

  // A write port takes effect only when enabled and not aimed at R0.
  for (genvar k = 0; k < NW; k++) begin : g_wdec
    assign wr_ok[k] = (bus.we[k] == WRITE_ENABLE) && (bus.waddr[k*AW +: AW] != {AW{1'b0}});
  end

  // Register array; later (higher-index) ports overwrite earlier ones on the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= {DW{1'b0}};
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_ok[k]) begin
          regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*DW +: DW];
        end
      end
    end
  end

  // Per read port: find the winning (highest-index) write hitting the read address.
  always_comb begin
    whit = {NR{1'b0}};
    for (int j = 0; j < NR; j++) begin
      wbyp[j] = {DW{1'b0}};
      for (int k = 0; k < NW; k++) begin
        if ((bus.we[k] == WRITE_ENABLE) && (bus.waddr[k*AW +: AW] == bus.raddr[j*AW +: AW])) begin
          whit[j] = 1'b1;
          wbyp[j] = bus.wdata[k*DW +: DW];
        end else begin
          wbyp[j] = wbyp[j];
        end
      end
    end
  end

  // Read muxes: zero for reset/disabled/R0, bypassed write data, else stored value.
  always_comb begin
    rdata_c = {(NR*DW){1'b0}};
    rbusy_c = {NR{SB_FREE}};
    for (int j = 0; j < NR; j++) begin
      if (rst || (bus.re[j] != READ_ENABLE) || (bus.raddr[j*AW +: AW] == {AW{1'b0}})) begin
        rdata_c[j*DW +: DW] = {DW{1'b0}};
        rbusy_c[j]          = SB_FREE;
      end else if ((BYPASS != 0) && whit[j]) begin
        rdata_c[j*DW +: DW] = wbyp[j];
        rbusy_c[j]          = SB_FREE;
      end else begin
        rdata_c[j*DW +: DW] = regs[bus.raddr[j*AW +: AW]];
        rbusy_c[j]          = sb_busy[j];
      end
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;

  regfile_mp_sb #(
    .AW (AW),
    .NR (NR),
    .NW (NW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (bus.we),
    .waddr    (bus.waddr),
    .set_en   (bus.set_en),
    .set_addr (bus.set_addr),
    .raddr    (bus.raddr),
    .busy     (sb_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance driven identically and
// compared against an array/scoreboard reference model plus directed literal checks.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic             set_en;
  logic [AW-1:0]    set_addr;

  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus_b ();
  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus_n ();

  assign bus_b.we = we;         assign bus_n.we = we;
  assign bus_b.waddr = waddr;   assign bus_n.waddr = waddr;
  assign bus_b.wdata = wdata;   assign bus_n.wdata = wdata;
  assign bus_b.re = re;         assign bus_n.re = re;
  assign bus_b.raddr = raddr;   assign bus_n.raddr = raddr;
  assign bus_b.set_en = set_en; assign bus_n.set_en = set_en;
  assign bus_b.set_addr = set_addr; assign bus_n.set_addr = set_addr;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .BYPASS(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b));
  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .BYPASS(0)) dut_n (
    .clk (clk), .rst (rst), .bus (bus_n));

  // Reference model: architectural register values and outstanding-producer flags.
  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];
  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] exp_rd(int j, bit byp);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (rst || !re[j] || a == 5'd0) return 32'd0;
    if (byp) begin
      for (int k = NW - 1; k >= 0; k--) begin
        if (we[k] && waddr[k*AW +: AW] == a) return wdata[k*DW +: DW];
      end
    end
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int j, bit byp);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (rst || !re[j] || a == 5'd0) return 1'b0;
    if (byp) begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && waddr[k*AW +: AW] == a) return 1'b0;
      end
    end
    return m_pend[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < NR; j++) begin
      check($sformatf("%s.b.rd%0d", tag, j), bus_b.rdata[j*DW +: DW], exp_rd(j, 1'b1));
      check($sformatf("%s.n.rd%0d", tag, j), bus_n.rdata[j*DW +: DW], exp_rd(j, 1'b0));
      check($sformatf("%s.b.busy%0d", tag, j), {31'd0, bus_b.rbusy[j]}, {31'd0, exp_busy(j, 1'b1)});
      check($sformatf("%s.n.busy%0d", tag, j), {31'd0, bus_n.rbusy[j]}, {31'd0, exp_busy(j, 1'b0)});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && waddr[k*AW +: AW] != 5'd0) begin
          m_regs[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
          m_pend[waddr[k*AW +: AW]] = 1'b0;
        end
      end
      if (set_en && set_addr != 5'd0) m_pend[set_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    we = 2'b00; waddr = 10'd0; wdata = 64'd0;
    re = 2'b00; raddr = 10'd0; set_en = 1'b0; set_addr = 5'd0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = 1'b1; waddr[k*AW +: AW] = a; wdata[k*DW +: DW] = d;
  endtask

  task automatic rd(input int j, input logic [AW-1:0] a);
    re[j] = 1'b1; raddr[j*AW +: AW] = a;
  endtask

  // Inputs are driven just after a falling edge; check, take the rising edge, return to falling.
  task automatic cyc(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    re = 2'b11; raddr = {5'd4, 5'd4};
    wr(0, 5'd4, 32'hCAFE0004);
    #2 check_all("rst_hold");
    check("rst_hold_lit", bus_b.rdata[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back next cycle.
    idle(); wr(0, 5'd5, 32'hDEADBEEF); cyc("w5");
    idle(); rd(0, 5'd5);
    #1 check("r5_lit", bus_b.rdata[31:0], 32'hDEADBEEF);
    cyc("r5");

    // Same-cycle bypass versus old value.
    idle(); wr(1, 5'd7, 32'h1234); rd(1, 5'd7);
    #1 check("byp7_b", bus_b.rdata[63:32], 32'h1234);
    check("byp7_n", bus_n.rdata[63:32], 32'h0);
    cyc("byp7");
    idle(); rd(1, 5'd7);
    #1 check("r7_n", bus_n.rdata[63:32], 32'h1234);
    cyc("r7");

    // Two writes to the same address: port 1 wins.
    idle(); wr(0, 5'd3, 32'd1); wr(1, 5'd3, 32'd2); rd(0, 5'd3);
    #1 check("prio_byp", bus_b.rdata[31:0], 32'd2);
    cyc("prio");
    idle(); rd(0, 5'd3); rd(1, 5'd3);
    #1 check("prio_reg", bus_n.rdata[31:0], 32'd2);
    cyc("prio_rd");

    // Scoreboard set, clear, and set-wins-over-clear.
    idle(); set_en = 1'b1; set_addr = 5'd9; rd(0, 5'd9);
    #1 check("sb_notyet", {31'd0, bus_b.rbusy[0]}, 32'd0);
    cyc("sb_set");
    idle(); rd(0, 5'd9);
    #1 check("sb_busy", {31'd0, bus_b.rbusy[0]}, 32'd1);
    cyc("sb_busy");
    idle(); wr(0, 5'd9, 32'h55); rd(0, 5'd9);
    #1 check("sb_wb_b", {31'd0, bus_b.rbusy[0]}, 32'd0);
    check("sb_wb_n", {31'd0, bus_n.rbusy[0]}, 32'd1);
    cyc("sb_wb");
    idle(); rd(0, 5'd9);
    #1 check("sb_clr", {31'd0, bus_n.rbusy[0]}, 32'd0);
    cyc("sb_clr");
    idle(); set_en = 1'b1; set_addr = 5'd9; wr(1, 5'd9, 32'h66); cyc("sb_both");
    idle(); rd(0, 5'd9);
    #1 check("sb_setwins", {31'd0, bus_b.rbusy[0]}, 32'd1);
    cyc("sb_setwins");
    idle(); wr(0, 5'd9, 32'h77); cyc("sb_drain");

    // R0 is immutable and never busy.
    idle(); wr(0, 5'd0, 32'hFFFF); set_en = 1'b1; set_addr = 5'd0; rd(0, 5'd0);
    #1 check("r0_byp", bus_b.rdata[31:0], 32'd0);
    cyc("r0_w");
    idle(); rd(0, 5'd0); rd(1, 5'd0);
    #1 check("r0_rd", bus_b.rdata[31:0], 32'd0);
    check("r0_busy", {31'd0, bus_b.rbusy[0]}, 32'd0);
    cyc("r0_rd");

    // Randomised traffic, addresses concentrated to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      we = 2'($urandom);
      re = 2'($urandom);
      for (int k = 0; k < NW; k++) begin
        waddr[k*AW +: AW] = 5'($urandom_range(0, 15));
        wdata[k*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NR; j++) raddr[j*AW +: AW] = 5'($urandom_range(0, 15));
      set_en = ($urandom_range(0, 2) == 0);
      set_addr = 5'($urandom_range(0, 15));
      cyc("rnd");
    end

    // Reset asserted mid-cycle clears state immediately; the edge during reset is lost.
    idle(); wr(0, 5'd12, 32'hABC); set_en = 1'b1; set_addr = 5'd13; cyc("pre_rst");
    idle(); rd(0, 5'd12); rd(1, 5'd13); wr(1, 5'd12, 32'h999); set_en = 1'b1; set_addr = 5'd12;
    #1 check("pre_rst_busy", {31'd0, bus_n.rbusy[1]}, 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all("rst_mid");
    check("rst_mid_lit", bus_b.rdata[31:0], 32'd0);
    check("rst_mid_busy", {31'd0, bus_n.rbusy[1]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(); rd(0, 5'd12); rd(1, 5'd13);
    #1 check("post_rst_rd", bus_n.rdata[31:0], 32'd0);
    cyc("post_rst");
    idle(); wr(0, 5'd12, 32'h4321); set_en = 1'b1; set_addr = 5'd13; cyc("post_rst_w");
    idle(); rd(0, 5'd12); rd(1, 5'd13);
    #1 check("post_rst_val", bus_n.rdata[31:0], 32'h4321);
    check("post_rst_set", {31'd0, bus_b.rbusy[1]}, 32'd1);
    cyc("post_rst_rd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
